// File: rtl/regfile_wb_if.sv
// Writeback bus between the two requesters (ALU and memory unit), the
// arbiter and the register-file write port.
interface regfile_wb_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  // ALU writeback request
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  // memory writeback request
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_ready;
  // registered register-file write port
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  // requester / register-file side
  modport master (
    output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
    input  a_ready, m_ready, we, wa, wd
  );

  // arbiter side
  modport slave (
    input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
    output a_ready, m_ready, we, wa, wd
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 32 x 64-bit
// register file. Two requesters (ALU, memory) share the single write port
// round-robin; the winning request is forwarded as a registered we/wa/wd.
//
// Handshake: a request transfers on any cycle where x_valid && x_ready.
// A requester keeps valid/addr/data stable until it sees ready. ready is
// combinational from both valid inputs and the last-grant register only,
// never from ready itself or from the issue port, and is forced low while
// rst_n is low.
module regfile_wb_arbiter #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_wb_if.slave   bus,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  output logic [31:0]   busy,
  output logic [CW-1:0] conflict_cnt,
  output logic          last_dbg
);

  // Which requester received the most recent grant.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_M = 1'b1
  } last_e;

  last_e         last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          grant_a;
  logic          grant_m;

  // Round-robin grant: a lone requester always wins; on a conflict the one
  // that was not granted last time wins.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (rst_n) begin
      grant_a = bus.a_valid && (!bus.m_valid || (last_q == LAST_M));
      grant_m = bus.m_valid && (!bus.a_valid || (last_q == LAST_A));
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.m_ready = grant_m;

  // Next-state for grant history, write port, scoreboard and counter.
  always_comb begin
    last_d = last_q;
    we_d   = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;

    // Grant history only moves when someone is actually granted.
    if (grant_a) begin
      last_d = LAST_A;
    end else if (grant_m) begin
      last_d = LAST_M;
    end

    // Writes to x0 are accepted but dropped; wa/wd keep showing the last
    // real write so they only ever change together with we.
    if (grant_a && (bus.a_addr != '0)) begin
      we_d = 1'b1;
      wa_d = bus.a_addr;
      wd_d = bus.a_data;
    end else if (grant_m && (bus.m_addr != '0)) begin
      we_d = 1'b1;
      wa_d = bus.m_addr;
      wd_d = bus.m_data;
    end

    // Clear on the commit edge first, then set, so a newly issued producer
    // for the same register keeps the bit pending.
    if (we_q) begin
      busy_d[wa_q] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;

    // Saturating count of cycles where both requesters wanted the port.
    if (bus.a_valid && bus.m_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset drops any pending write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_M;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.we       = we_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign busy         = busy_q;
  assign conflict_cnt = cnt_q;
  assign last_dbg     = (last_q == LAST_M);

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32 x 64-bit register file. It shares the register file's single write port between two writeback requesters: the ALU (`a_*`) and the load/memory unit (`m_*`). Requests are granted round-robin and forwarded as a registered `we`/`wa`/`wd` triple. A pending-write scoreboard (`busy`) is also kept for the issue stage's hazard checks.

## Interface
Parameters:
- `DW`, 64, data width; matches the register file word.
- `AW`, 5, register address width (32 registers).
- `CW`, 16, width of the conflict performance counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  ALU writeback request.
- `a_addr`  in  AW  ALU destination register.
- `a_data`  in  DW  ALU result.
- `a_ready`  out  1  ALU request accepted this cycle (combinational).
- `m_valid`  in  1  memory writeback request.
- `m_addr`  in  AW  memory destination register.
- `m_data`  in  DW  load data.
- `m_ready`  out  1  memory request accepted this cycle (combinational).
- `issue_valid`  in  1  an instruction with destination `issue_addr` has issued.
- `issue_addr`  in  AW  destination of the issuing instruction.
- `we`  out  1  register-file write enable (registered).
- `wa`  out  AW  register-file write address (registered).
- `wd`  out  DW  register-file write data (registered).
- `busy`  out  32  scoreboard; bit i set means a write to register i is pending.
- `conflict_cnt`  out  CW  saturating count of cycles in which both requesters were valid.

## Operation
- **Handshake**
  - A request transfers on a cycle where `x_valid && x_ready`.
  - A requester holds `valid`, `addr` and `data` stable until it sees `ready`.
  - `ready` never depends on `ready`. It is a function of both `valid` inputs and the `last` grant register only.
- **Arbitration**
  - At most one grant per cycle.
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last time wins.
  - The 1-bit `last` register updates only on a grant.
  - Reset value of `last` = M, so A wins the first conflict.
- **Write path**
  - On a grant, the chosen addr and data are registered into `wa`/`wd`.
  - `we` is registered as 1 when the granted address is non-zero.
  - No grant, or a granted address of 0: `we` is registered as 0.
  - A request to x0 is still accepted (`ready`=1) and silently discarded.
  - `wa`/`wd` hold their last values while `we`=0.
- **Scoreboard**
  - Set: at the edge ending a cycle with `issue_valid`=1 and `issue_addr`≠0, bit `issue_addr` is set.
  - Clear: at the edge ending a cycle with `we`=1, bit `wa` is cleared. This is the same edge at which the register file commits the write.
  - Set and clear on the same bit at the same edge: set wins, because a newer producer is now pending.
  - `busy[0]` is constant 0.
- **Counter**: `conflict_cnt` increments on each cycle with `a_valid && m_valid`, and saturates at all-ones.

## Timing
- Reset (asynchronous assert, synchronous release by clock): `we`=0, `wa`=0, `wd`=0, `busy`=0, `conflict_cnt`=0, `last`=M.
- While `rst_n`=0: `a_ready`=`m_ready`=0.
- Reset asserted mid-transfer: any registered write is dropped, with `we` low immediately. Requesters re-present their requests after reset.
- Latency:
  - Grant at cycle T gives `we`/`wa`/`wd` valid throughout T+1.
  - The register file updates at the end of T+1.
  - `busy` clears at that same edge.
- Throughput: one write per cycle sustained. The losing requester waits exactly one cycle when both stream continuously.
- A and M valid with the same address in one cycle: both writes are performed on consecutive cycles in grant order. The last one granted defines the final value.
- `ready` outputs are combinational from inputs and state; no combinational path from `issue_*` to `ready`.

## Test plan
- **Reset values**: hold `rst_n`=0 with both requesters valid → `a_ready`=`m_ready`=0, `we`=0, `busy`=0. Release reset → A granted first.
- **Single write and scoreboard**:
  - Stimulus: issue r5 at cycle 0; A writes r5=0x1234 at cycle 3.
  - Required: `busy[5]`=1 during cycles 1-4; `we`=1, `wa`=5, `wd`=0x1234 in cycle 4; `busy[5]`=0 from cycle 5.
- **Round-robin**:
  - Stimulus: both requesters continuously valid with distinct addresses for 6 cycles.
  - Required: grants alternate A,M,A,M,A,M; `conflict_cnt`=6.
- **x0 discard**: A writes r0=0xFFFF → `a_ready`=1 and `we`=0 the next cycle; `busy[0]` stays 0 even after `issue_addr`=0.
- **Set/clear collision**: `we`=1, `wa`=7 in the same cycle as `issue_valid` with `issue_addr`=7 → `busy[7]` remains 1 afterwards.
- **Counter saturation and mid-op reset**:
  - Preload `conflict_cnt` near max (CW=4 build) and hold both valid for 20 cycles → counter sticks at 15.
  - Then pulse `rst_n` low while `we`=1 → `we` drops immediately and all state returns to reset values.
